// File: rtl/traffic_pkg.sv
// Shared types, lamp encodings and helpers for the traffic light sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN     = 3'd0,
    MAIN_YELLOW    = 3'd1,
    ALL_RED_1      = 3'd2,
    COUNTRY_GREEN  = 3'd3,
    COUNTRY_YELLOW = 3'd4,
    ALL_RED_2      = 3'd5,
    NIGHT_FLASH    = 3'd6
  } LIGHT_STATE_T;

  // Lamp encodings: {RED, YELLOW, GREEN}
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] DARK   = 3'b000;

  // Timer load value (dwell-1) for a country green sized from the traffic rank.
  function automatic logic [7:0] cg_load(input logic [9:0] base,
                                         input logic [9:0] step,
                                         input logic [9:0] cap,
                                         input logic [4:0] rank);
    logic [9:0] d;
    d = base + 10'(rank) * step;
    if (d > cap) d = cap;
    if (d == '0) d = 10'd1;
    d = d - 10'd1;
    return 8'(d);
  endfunction

  function automatic logic [2:0] main_lamp(input LIGHT_STATE_T s, input logic blink);
    logic [2:0] l;
    case (s)
      MAIN_GREEN:  l = GREEN;
      MAIN_YELLOW: l = YELLOW;
      NIGHT_FLASH: l = blink ? YELLOW : DARK;
      default:     l = RED;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] country_lamp(input LIGHT_STATE_T s);
    logic [2:0] l;
    case (s)
      COUNTRY_GREEN:  l = GREEN;
      COUNTRY_YELLOW: l = YELLOW;
      default:        l = RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// 8-bit loadable down-counter that saturates at zero.
module phase_timer #(
  parameter logic [7:0] RST_VAL = '0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [7:0] LOAD_VAL,
  output logic       ZERO
);

  logic [7:0] cnt_q;

  // Load has priority over counting; hold at zero once reached.
  always_ff @(posedge CLK) begin
    if (RST)                cnt_q <= RST_VAL;
    else if (LOAD)          cnt_q <= LOAD_VAL;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 8'd1;
  end

  assign ZERO = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_sequencer.sv
// Moore sequencer for the main-road and country-road signal heads, with
// latched country requests, rank-sized country green and night flashing.
module traffic_light_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_MAIN_GREEN = 20,
  parameter int unsigned YELLOW_T       = 3,
  parameter int unsigned ALL_RED_T      = 1,
  parameter int unsigned CG_BASE        = 5,
  parameter int unsigned CG_STEP        = 1,
  parameter int unsigned CG_MAX         = 25,
  parameter int unsigned BLINK_T        = 4,
  parameter int unsigned NIGHT_START    = 22,
  parameter int unsigned NIGHT_END      = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       COUNTRY_PULSE,
  input  logic [4:0] LIGHT_RANK,
  input  logic [4:0] HOUR,
  output logic [2:0] MAIN_LIGHT,
  output logic [2:0] COUNTRY_LIGHT,
  output logic [2:0] PHASE,
  output logic       REQ_PENDING,
  output logic       CYCLE_DONE
);

  localparam logic [7:0] MG_LD    = 8'(MIN_MAIN_GREEN - 1);
  localparam logic [7:0] Y_LD     = 8'(YELLOW_T - 1);
  localparam logic [7:0] AR_LD    = 8'(ALL_RED_T - 1);
  localparam logic [7:0] BLINK_LD = 8'(BLINK_T - 1);
  localparam logic [4:0] NS       = 5'(NIGHT_START);
  localparam logic [4:0] NE       = 5'(NIGHT_END);

  LIGHT_STATE_T state_q, state_d;
  logic         req_q, req_d;
  logic         blink_q, blink_d;
  logic         done_q, done_d;
  logic [2:0]   main_q, country_q;
  logic         tmr_load, tmr_zero;
  logic [7:0]   tmr_val;
  logic         req, night;

  phase_timer #(.RST_VAL(MG_LD)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .LOAD     (tmr_load),
    .LOAD_VAL (tmr_val),
    .ZERO     (tmr_zero)
  );

  // Next-state, timer reload, request latch and blink phase decisions.
  always_comb begin
    req      = req_q | COUNTRY_PULSE;
    night    = (HOUR <= 5'd23) && ((HOUR >= NS) || (HOUR < NE));
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      MAIN_GREEN: if (tmr_zero) begin
        if (req)        state_d = MAIN_YELLOW;
        else if (night) state_d = NIGHT_FLASH;
      end
      MAIN_YELLOW:    if (tmr_zero) state_d = ALL_RED_1;
      ALL_RED_1:      if (tmr_zero) state_d = COUNTRY_GREEN;
      COUNTRY_GREEN:  if (tmr_zero) state_d = COUNTRY_YELLOW;
      COUNTRY_YELLOW: if (tmr_zero) state_d = ALL_RED_2;
      ALL_RED_2:      if (tmr_zero) state_d = MAIN_GREEN;
      NIGHT_FLASH: begin
        if (req)         state_d = MAIN_YELLOW;
        else if (!night) state_d = MAIN_GREEN;
        else if (tmr_zero) begin
          // the phase timer doubles as the blink half-period counter
          tmr_load = 1'b1;
          tmr_val  = BLINK_LD;
        end
      end
      default: state_d = MAIN_GREEN;
    endcase

    if (state_d != state_q) begin
      tmr_load = 1'b1;
      case (state_d)
        MAIN_GREEN:     tmr_val = MG_LD;
        MAIN_YELLOW:    tmr_val = Y_LD;
        COUNTRY_GREEN:  tmr_val = cg_load(10'(CG_BASE), 10'(CG_STEP), 10'(CG_MAX), LIGHT_RANK);
        COUNTRY_YELLOW: tmr_val = Y_LD;
        NIGHT_FLASH:    tmr_val = BLINK_LD;
        default:        tmr_val = AR_LD;
      endcase
    end

    if ((state_d == COUNTRY_GREEN) && (state_q != COUNTRY_GREEN)) req_d = 1'b0;
    else if (COUNTRY_PULSE && (state_q != COUNTRY_GREEN))          req_d = 1'b1;
    else                                                           req_d = req_q;

    if (state_d != NIGHT_FLASH)      blink_d = 1'b0;
    else if (state_q != NIGHT_FLASH) blink_d = 1'b1;
    else if (tmr_zero)               blink_d = ~blink_q;
    else                             blink_d = blink_q;

    done_d = (state_q == ALL_RED_2) && (state_d == MAIN_GREEN);
  end

  // State register with lamp outputs registered from the next-state decode.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= MAIN_GREEN;
      req_q     <= 1'b0;
      blink_q   <= 1'b0;
      done_q    <= 1'b0;
      main_q    <= GREEN;
      country_q <= RED;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      blink_q   <= blink_d;
      done_q    <= done_d;
      main_q    <= main_lamp(state_d, blink_d);
      country_q <= country_lamp(state_d);
    end
  end

  assign MAIN_LIGHT    = main_q;
  assign COUNTRY_LIGHT = country_q;
  assign PHASE         = state_q;
  assign REQ_PENDING   = req_q;
  assign CYCLE_DONE    = done_q;

endmodule

// File: doc/traffic_light_sequencer.md
# traffic_light_sequencer

Moore state machine that drives the main-road and country-road signal heads. It serves country-road requests raised by the car-counting controller's `COUNTRY_PULSE` and sizes each country green from the memory-derived `LIGHT_RANK`. Between requests it runs a night flashing mode selected by `HOUR`. The block sits beside the controller on the system bus and is the sole owner of `MAIN_LIGHT`, which the controller reads back.

## Interface
Parameters:
- `MIN_MAIN_GREEN`, 20: minimum main-green dwell, cycles
- `YELLOW_T`, 3: yellow dwell, cycles
- `ALL_RED_T`, 1: all-red clearance dwell, cycles
- `CG_BASE`, 5: base country-green dwell, cycles
- `CG_STEP`, 1: country-green cycles added per `LIGHT_RANK` unit
- `CG_MAX`, 25: country-green cap, cycles
- `BLINK_T`, 4: night blink half-period, cycles
- `NIGHT_START`, 22; `NIGHT_END`, 6: night hours

Ports:
- `CLK` in 1: clock
- `RST` in 1: synchronous, active-high reset
- `COUNTRY_PULSE` in 1: one-cycle country service request
- `LIGHT_RANK` in 5: unsigned traffic rank
- `HOUR` in 5: hour of day, 0..23
- `MAIN_LIGHT` out 3: {RED, YELLOW, GREEN}; bit0 = green
- `COUNTRY_LIGHT` out 3: {RED, YELLOW, GREEN}
- `PHASE` out 3: current state encoding
- `REQ_PENDING` out 1: latched, unserved request
- `CYCLE_DONE` out 1: one-cycle pulse at the end of a country service

## Operation
- States: MAIN_GREEN, MAIN_YELLOW, ALL_RED_1, COUNTRY_GREEN, COUNTRY_YELLOW, ALL_RED_2, NIGHT_FLASH.
- Lights per state:
  - MAIN_GREEN: main 001, country 100
  - MAIN_YELLOW: main 010, country 100
  - ALL_RED_*: main 100, country 100
  - COUNTRY_GREEN: main 100, country 001
  - COUNTRY_YELLOW: main 100, country 010
  - NIGHT_FLASH: main toggles 010/000 every `BLINK_T` cycles, starting at 010; country 100
- Request latch:
  - `REQ_PENDING` is set by `COUNTRY_PULSE` in every state except COUNTRY_GREEN; pulses arriving in COUNTRY_GREEN are dropped.
  - It clears on entry to COUNTRY_GREEN. Clear wins over a simultaneous pulse.
- `req` = `REQ_PENDING` | `COUNTRY_PULSE`.
- `night` = (`HOUR` >= `NIGHT_START` or `HOUR` < `NIGHT_END`) and `HOUR` <= 23. `HOUR` > 23 counts as day.
- Transitions:
  - MAIN_GREEN, timer == 0: `req` -> MAIN_YELLOW; else `night` -> NIGHT_FLASH; else hold, timer stays 0.
  - MAIN_YELLOW -> ALL_RED_1 -> COUNTRY_GREEN -> COUNTRY_YELLOW -> ALL_RED_2 -> MAIN_GREEN, each move taken when its timer reaches 0.
  - NIGHT_FLASH: `req` -> MAIN_YELLOW (takes priority); else !`night` -> MAIN_GREEN.
- Country-green dwell = min(`CG_BASE` + `LIGHT_RANK`*`CG_STEP`, `CG_MAX`).
  - Computed in 10-bit unsigned arithmetic.
  - `LIGHT_RANK` is sampled on the cycle ALL_RED_1 exits. Later changes do not affect the running green.
  - A dwell of 0 is forced to 1.
- `CYCLE_DONE` = 1 for the single cycle in which ALL_RED_2 transitions to MAIN_GREEN.

## Timing
- All outputs are registered and change the cycle after the state register updates, i.e. they are a registered decode of the next state.
- Timer:
  - Loaded with dwell-1 on entry to a state; the state lasts exactly dwell cycles.
  - Entry to MAIN_GREEN loads `MIN_MAIN_GREEN`-1.
- Request latency: with the minimum dwell expired, a pulse in MAIN_GREEN at cycle N makes `MAIN_LIGHT` = 010 at cycle N+1.
- Reset: takes effect at the next `CLK` edge, from any state, including mid-sequence. After reset:
  - state MAIN_GREEN, timer = `MIN_MAIN_GREEN`-1
  - `MAIN_LIGHT` = 001, `COUNTRY_LIGHT` = 100
  - `PHASE` = MAIN_GREEN, `REQ_PENDING` = 0, `CYCLE_DONE` = 0, blink phase cleared
  - A `COUNTRY_PULSE` coincident with `RST` is discarded.
- Safety invariant: main and country are never both non-red in the same cycle.

## Structure
- Shared package `traffic_pkg` holds:
  - `LIGHT_STATE_T` enum (3-bit, MAIN_GREEN = 0)
  - light encodings `RED` = 3'b100, `YELLOW` = 3'b010, `GREEN` = 3'b001, `DARK` = 3'b000
- Sub-module `phase_timer`: 8-bit loadable down-counter with `LOAD`, `LOAD_VAL`, `ZERO` outputs; saturates at 0.
- Top level holds the FSM, request latch, dwell computation and blink toggle.

## Test plan
- Reset, no pulses, `HOUR` = 12: `MAIN_LIGHT` stays 001 and `COUNTRY_LIGHT` stays 100 for 100 cycles; `REQ_PENDING` = 0.
- Pulse at cycle 5, `LIGHT_RANK` = 7, defaults:
  - main green until cycle 20, yellow 3 cycles, all-red 1 cycle
  - country green 12 cycles, country yellow 3 cycles, all-red 1 cycle
  - `CYCLE_DONE` high for 1 cycle, then main green again
- `LIGHT_RANK` = 31: country green lasts 25 cycles (cap). Changing `LIGHT_RANK` to 0 mid-green has no effect on the running green.
- Pulse during COUNTRY_GREEN: ignored, `REQ_PENDING` stays 0. A pulse during COUNTRY_YELLOW latches and triggers a new service after the next 20-cycle main green.
- `HOUR` = 23, no request:
  - NIGHT_FLASH entered after main green; main toggles 010/000 every 4 cycles.
  - A pulse exits via MAIN_YELLOW.
  - Setting `HOUR` to 7 instead returns to MAIN_GREEN.
- `RST` asserted mid COUNTRY_GREEN together with a pulse: next cycle `MAIN_LIGHT` = 001, `COUNTRY_LIGHT` = 100, `REQ_PENDING` = 0.
